fetch_stage: RTL

//   Instruction-fetch stage that feeds the IF/ID pipeline register with irF/pcplusF each cycle.
//   - Owns the PC.
//   - Issues requests to instruction memory over a req/ack handshake; memory may answer in the same cycle or later.
//   - Applies branch/jump redirects and downstream stalls.
//   - Emits a NOP bubble (32'h0) whenever no valid instruction is delivered.

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ack handshake, applies redirects and decode stalls, and registers the
// instruction handed to IF/ID (32'h0 is the bubble).
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned redirect
// targets through a sticky fetch_fault that shuts fetching off until reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] irF,
  output logic [31:0] pcplusF,
  output logic        validF,
  output logic        fetch_fault
);

  // S_FETCH: request at pc. S_HOLD: instruction parked behind a stall.
  // S_DRAIN: waiting out the ack of a request abandoned by a redirect.
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_inc;
  logic [31:0] ir_n, pcplus_n;
  logic        valid_n;
  logic [31:0] buf_ir, buf_ir_n, buf_pcplus, buf_pcplus_n;
  logic [31:0] drain_addr, drain_addr_n;
  logic [31:0] target;
  logic        fault;
  logic        handshake;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target = redirect_pc;

  // Sticky fault: any misaligned redirect latches it until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      fault <= 1'b1;
    end
  end
`else
  // Low address bits are simply dropped when the alignment check is off.
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign fault  = 1'b0;
`endif

  assign fetch_fault = fault;
  assign pc_inc      = pc + 32'd4;
  assign handshake   = imem_req && imem_ack;

  // Next-state, request and output-register selection.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n      = state;
    pc_n         = pc;
    ir_n         = irF;
    pcplus_n     = pcplusF;
    valid_n      = validF;
    buf_ir_n     = buf_ir;
    buf_pcplus_n = buf_pcplus;
    drain_addr_n = drain_addr;
    imem_req     = 1'b0;
    imem_addr    = pc;

    case (state)
      S_FETCH: begin
        imem_req  = !rst && !fault;
        imem_addr = pc;
        if (imem_req && imem_ack) begin
          pc_n = pc_inc;
          if (stallD) begin
            buf_ir_n     = imem_rdata;
            buf_pcplus_n = pc_inc;
            state_n      = S_HOLD;
          end else begin
            ir_n     = imem_rdata;
            pcplus_n = pc_inc;
            valid_n  = 1'b1;
          end
        end else if (!stallD) begin
          ir_n     = 32'h0;
          pcplus_n = 32'h0;
          valid_n  = 1'b0;
        end
      end

      S_HOLD: begin
        if (!stallD) begin
          ir_n     = buf_ir;
          pcplus_n = buf_pcplus;
          valid_n  = 1'b1;
          state_n  = S_FETCH;
        end
      end

      S_DRAIN: begin
        imem_req  = !rst;
        imem_addr = drain_addr;
        if (imem_req && imem_ack) begin
          state_n = S_FETCH;
        end
        if (!stallD) begin
          ir_n     = 32'h0;
          pcplus_n = 32'h0;
          valid_n  = 1'b0;
        end
      end

      default: state_n = S_FETCH;
    endcase

    // A redirect overrides everything, including a stall.
    if (redirect) begin
      pc_n     = target;
      ir_n     = 32'h0;
      pcplus_n = 32'h0;
      valid_n  = 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_req && !imem_ack) begin
            drain_addr_n = pc;
            state_n      = S_DRAIN;
          end else begin
            state_n = S_FETCH;
          end
        end
        S_HOLD:  state_n = S_FETCH;
        // The pending ack may land in the same cycle; then the drain is done.
        S_DRAIN: state_n = handshake ? S_FETCH : S_DRAIN;
        default: state_n = S_FETCH;
      endcase
    end
  end

  // State, PC, output and buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      irF        <= 32'h0;
      pcplusF    <= 32'h0;
      validF     <= 1'b0;
      buf_ir     <= 32'h0;
      buf_pcplus <= 32'h0;
      drain_addr <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state      <= state_n;
      pc         <= pc_n;
      irF        <= ir_n;
      pcplusF    <= pcplus_n;
      validF     <= valid_n;
      buf_ir     <= buf_ir_n;
      buf_pcplus <= buf_pcplus_n;
      drain_addr <= drain_addr_n;
    end
  end

endmodule
